// File: rtl/flap_pkg.sv
// flap_pkg: shared types for the flap controller.
// The state encoding is also used by the score/display block, so the
// enum values must not be reordered.
package flap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } flap_state_t;

  // One-cycle motion commands sent to every column cell.
  typedef struct packed {
    logic key;
    logic gravity;
  } flap_cmd_t;

endpackage

// File: rtl/flap_ctrl_edge_sync.sv
// edge_sync: 2-FF synchronizer followed by a rising-edge detector.
//   clk     in  system clock
//   reset_n in  async active-low reset
//   d       in  raw asynchronous input
//   level   out synchronized level (second sync FF)
//   pulse   out one-cycle pulse on a synchronized rising edge
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic pulse
);

  // [0],[1] are the synchronizer; [2] is the delayed copy for edge detect.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], d};
  end

  assign level = sync_q[1];
  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/flap_ctrl.sv
// flap_ctrl: turns the flap button into one-cycle key pulses and a free
// running divider into one-cycle gravity pulses, and owns the game state.
//   clk      in  system clock
//   reset_n  in  async active-low reset
//   key_in   in  raw flap button (async)
//   pause_in in  raw pause switch (async, level)
//   crash    in  collision flag (sync, level)
//   key      out flap pulse, registered
//   gravity  out fall pulse, registered
//   pause    out high whenever state != RUN, registered
//   state_o  out current state
module flap_ctrl
  import flap_pkg::*;
#(
  parameter int GRAV_PERIOD = 12_500_000,
  parameter int FLAP_HOLD   = 2_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_in,
  input  logic       pause_in,
  input  logic       crash,
  output logic       key,
  output logic       gravity,
  output logic       pause,
  output logic [1:0] state_o
);

  localparam int GW = $clog2(GRAV_PERIOD);
  localparam int HW = $clog2(FLAP_HOLD + 1);
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(FLAP_HOLD);

  flap_state_t   state, state_nxt;
  flap_cmd_t     cmd_nxt;
  logic [GW-1:0] grav_cnt, grav_cnt_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;

  logic flap_req, sync_pause;
  logic unused_key_lvl, unused_pause_rise;

  edge_sync u_key_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (key_in),
    .level   (unused_key_lvl),
    .pulse   (flap_req)
  );

  edge_sync u_pause_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pause_in),
    .level   (sync_pause),
    .pulse   (unused_pause_rise)
  );

  // A crash only counts once the game has started.
  logic crash_hit;
  assign crash_hit = crash && (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (crash_hit) state_nxt = OVER;
    else begin
      unique case (state)
        IDLE:    if (flap_req)    state_nxt = RUN;
        RUN:     if (sync_pause)  state_nxt = PAUSED;
        PAUSED:  if (!sync_pause) state_nxt = RUN;
        default: state_nxt = OVER;
      endcase
    end
  end

  // Pulse and counter next values. Key and gravity live in exclusive
  // branches, so they can never coincide; a flap also restarts the
  // gravity period to give a full grace period.
  always_comb begin
    cmd_nxt      = '0;
    grav_cnt_nxt = grav_cnt;
    hold_cnt_nxt = hold_cnt;
    if (!crash_hit) begin
      unique case (state)
        IDLE: begin
          grav_cnt_nxt = '0;
          if (flap_req) begin
            cmd_nxt.key  = 1'b1;
            hold_cnt_nxt = HOLD_LOAD;
          end
        end
        RUN: begin
          if (hold_cnt != '0) hold_cnt_nxt = hold_cnt - 1'b1;
          if (sync_pause) begin
            // leaving RUN: drop the flap, keep the gravity phase
          end else if (flap_req && (hold_cnt == '0)) begin
            cmd_nxt.key  = 1'b1;
            grav_cnt_nxt = '0;
            hold_cnt_nxt = HOLD_LOAD;
          end else if (grav_cnt == GRAV_LAST) begin
            cmd_nxt.gravity = 1'b1;
            grav_cnt_nxt    = '0;
          end else begin
            grav_cnt_nxt = grav_cnt + 1'b1;
          end
        end
        default: ;  // PAUSED / OVER: everything frozen
      endcase
    end
  end

  // Registered outputs and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key      <= 1'b0;
      gravity  <= 1'b0;
      pause    <= 1'b1;
      grav_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      key      <= cmd_nxt.key;
      gravity  <= cmd_nxt.gravity;
      pause    <= (state_nxt != RUN);
      grav_cnt <= grav_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_flap_ctrl.sv
module tb_flap_ctrl;
  import flap_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_in, pause_in, crash;
  logic       key, gravity, pause;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  flap_ctrl #(.GRAV_PERIOD(8), .FLAP_HOLD(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_in   (key_in),
    .pause_in (pause_in),
    .crash    (crash),
    .key      (key),
    .gravity  (gravity),
    .pause    (pause),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs n cycles. key_in is high for the first kin_len cycles. A key pulse
  // is expected only at cycle key_at; gravity at gfirst and every gper after
  // it (gper=0: only once). exp_pause<0 skips the pause check.
  task automatic window(input int n, input int kin_len, input int key_at,
                        input int gfirst, input int gper, input int exp_pause);
    for (int i = 1; i <= n; i++) begin
      logic eg;
      key_in = (i <= kin_len);
      tick();
      eg = (gfirst > 0) && ((i == gfirst) ||
           ((gper > 0) && (i > gfirst) && ((i - gfirst) % gper == 0)));
      chk("key", {31'd0, key}, {31'd0, (i == key_at)});
      chk("gravity", {31'd0, gravity}, {31'd0, eg});
      if (exp_pause >= 0) chk("pause", {31'd0, pause}, exp_pause[31:0]);
    end
  endtask

  initial begin
    reset_n = 1'b0; key_in = 1'b0; pause_in = 1'b0; crash = 1'b0;

    // Reset held 3 cycles
    tick(); tick(); tick();
    chk("rst_key", {31'd0, key}, 32'd0);
    chk("rst_gravity", {31'd0, gravity}, 32'd0);
    chk("rst_pause", {31'd0, pause}, 32'd1);
    chk("rst_state", {30'd0, state_o}, {30'd0, IDLE});
    reset_n = 1'b1;

    // Idle: no pulses
    window(20, 0, 0, 0, 0, 1);
    chk("idle_state", {30'd0, state_o}, {30'd0, IDLE});

    // Start: key 3 edges after the press, then gravity every 8 cycles
    window(3, 1, 3, 0, 0, -1);
    chk("start_state", {30'd0, state_o}, {30'd0, RUN});
    chk("start_pause", {31'd0, pause}, 32'd0);
    window(16, 0, 0, 8, 8, 0);

    // Flap with cooldown clear, gravity counter at 2 when it lands
    window(3, 1, 3, 0, 0, 0);
    // Press 2 cycles after the flap lands during cooldown: dropped
    window(1, 0, 0, 0, 0, 0);
    window(4, 1, 0, 0, 0, 0);
    // Press 6 cycles after: accepted on gravity terminal count (key wins),
    // next gravity 8 cycles after that key
    window(11, 1, 3, 11, 0, 0);

    // key_in held 30 cycles: one flap only
    window(30, 30, 3, 11, 8, 0);

    // Pause: synchronized pause reaches the FSM with grav_cnt=5
    key_in = 1'b0; pause_in = 1'b1;
    window(2, 0, 0, 0, 0, 0);
    window(21, 1, 0, 0, 0, 1);
    chk("paused_state", {30'd0, state_o}, {30'd0, PAUSED});
    pause_in = 1'b0;
    window(2, 0, 0, 0, 0, 1);
    // RUN resumes at cycle 1; gravity 3 cycles later
    window(4, 0, 0, 4, 0, 0);
    chk("resume_state", {30'd0, state_o}, {30'd0, RUN});

    // Crash coincident with flap_req: OVER, no key
    window(2, 1, 0, 0, 0, 0);
    crash = 1'b1;
    tick();
    chk("crash_key", {31'd0, key}, 32'd0);
    chk("crash_gravity", {31'd0, gravity}, 32'd0);
    chk("crash_state", {30'd0, state_o}, {30'd0, OVER});
    chk("crash_pause", {31'd0, pause}, 32'd1);
    crash = 1'b0;
    pause_in = 1'b1;
    window(10, 1, 0, 0, 0, 1);
    pause_in = 1'b0;
    window(10, 1, 0, 0, 0, 1);
    chk("over_sticky", {30'd0, state_o}, {30'd0, OVER});

    // Only reset leaves OVER
    reset_n = 1'b0;
    tick();
    chk("over_rst_state", {30'd0, state_o}, {30'd0, IDLE});
    reset_n = 1'b1;
    window(5, 0, 0, 0, 0, 1);

    // Async reset between edges clears an in-flight key pulse
    window(3, 1, 3, 0, 0, -1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_key", {31'd0, key}, 32'd0);
    chk("async_gravity", {31'd0, gravity}, 32'd0);
    chk("async_pause", {31'd0, pause}, 32'd1);
    chk("async_state", {30'd0, state_o}, {30'd0, IDLE});
    #3 reset_n = 1'b1;
    window(4, 0, 0, 0, 0, 1);
    chk("final_state", {30'd0, state_o}, {30'd0, IDLE});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
